// File: rtl/vga_pkg.sv
// Shared VGA timing definitions.
// Holds the default 640x480@60 timing constants, the derived frame
// totals, the coordinate width and the registered video output bundle.
package vga_pkg;

   localparam int unsigned COORD_W = 10;

   localparam int unsigned DEF_H_ACTIVE = 640;
   localparam int unsigned DEF_H_FP     = 16;
   localparam int unsigned DEF_H_SYNC   = 96;
   localparam int unsigned DEF_H_BP     = 48;
   localparam int unsigned DEF_V_ACTIVE = 480;
   localparam int unsigned DEF_V_FP     = 10;
   localparam int unsigned DEF_V_SYNC   = 2;
   localparam int unsigned DEF_V_BP     = 33;

   localparam int unsigned H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
   localparam int unsigned V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

   // Registered per-pixel video outputs, updated together.
   typedef struct packed {
      logic               hsync;
      logic               vsync;
      logic               de;
      logic [COORD_W-1:0] x;
      logic [COORD_W-1:0] y;
   } vid_t;

   // Blanked, sync-inactive state used at reset.
   localparam vid_t VID_IDLE = '{hsync: 1'b1, vsync: 1'b1, de: 1'b0, x: '0, y: '0};

   // Bits needed for a counter running 0..total-1.
   function automatic int unsigned cnt_width(input int unsigned total);
      return (total > 1) ? $clog2(total) : 1;
   endfunction

endpackage

// File: rtl/vga_timing_if.sv
// Video timing bundle produced by vga_timing.
// Signals: pix_en (pixel strobe), hsync/vsync (active-low syncs), de
// (display enable), x/y (active-area coordinates), line_start and
// frame_start (one-clock pulses).
// Modports: master drives the bundle, slave consumes it.
interface vga_timing_if;
   import vga_pkg::*;

   logic               pix_en;
   logic               hsync;
   logic               vsync;
   logic               de;
   logic [COORD_W-1:0] x;
   logic [COORD_W-1:0] y;
   logic               line_start;
   logic               frame_start;

   modport master (output pix_en, hsync, vsync, de, x, y, line_start, frame_start);
   modport slave  (input  pix_en, hsync, vsync, de, x, y, line_start, frame_start);

endinterface

// File: rtl/vga_timing_pix_en_gen.sv
// Pixel strobe divider.
// Ports: clk_i system clock, rst_i async active-high reset,
//        en_o one-clock strobe every CLK_DIV clocks (constant high when
//        CLK_DIV=1, low during reset).
module pix_en_gen #(
   parameter int unsigned CLK_DIV = 2
) (
   input  logic clk_i,
   input  logic rst_i,
   output logic en_o
);

   localparam int unsigned DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DW-1:0] LAST = DW'(CLK_DIV - 1);

   logic [DW-1:0] div_q, div_d;
   logic          en_q,  en_d;

   // Strobe is registered from the next divider value so it is high for
   // exactly the clock during which the divider sits at LAST.
   always_comb begin
      div_d = (div_q == LAST) ? '0 : div_q + DW'(1);
      en_d  = (div_d == LAST);
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         div_q <= '0;
         en_q  <= 1'b0;
      end else begin
         div_q <= div_d;
         en_q  <= en_d;
      end
   end

   assign en_o = en_q;

endmodule

// File: rtl/vga_timing.sv
// VGA raster timing generator.
// Ports: clk_i system clock, rst_i async active-high reset;
//        pix_en_o pixel strobe, hsync_o/vsync_o active-low syncs,
//        de_o display enable, x_o/y_o active-area coordinates (else 0),
//        line_start_o/frame_start_o one-clock pulses at h=0 / h=0,v=0.
// All video outputs are registered on the pix_en clock, so they follow
// the counter state by one clock and hold for CLK_DIV clocks.
module vga_timing
   import vga_pkg::*;
#(
   parameter int unsigned CLK_DIV  = 2,
   parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
   parameter int unsigned H_FP     = DEF_H_FP,
   parameter int unsigned H_SYNC   = DEF_H_SYNC,
   parameter int unsigned H_BP     = DEF_H_BP,
   parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
   parameter int unsigned V_FP     = DEF_V_FP,
   parameter int unsigned V_SYNC   = DEF_V_SYNC,
   parameter int unsigned V_BP     = DEF_V_BP
) (
   input  logic               clk_i,
   input  logic               rst_i,
   output logic               pix_en_o,
   output logic               hsync_o,
   output logic               vsync_o,
   output logic               de_o,
   output logic [COORD_W-1:0] x_o,
   output logic [COORD_W-1:0] y_o,
   output logic               line_start_o,
   output logic               frame_start_o
);

   localparam int unsigned H_TOT  = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOT  = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int unsigned HW     = cnt_width(H_TOT);
   localparam int unsigned VW     = cnt_width(V_TOT);
   localparam int unsigned HS_BEG = H_ACTIVE + H_FP;
   localparam int unsigned HS_END = H_ACTIVE + H_FP + H_SYNC;
   localparam int unsigned VS_BEG = V_ACTIVE + V_FP;
   localparam int unsigned VS_END = V_ACTIVE + V_FP + V_SYNC;
   localparam logic [HW-1:0] H_LAST = HW'(H_TOT - 1);
   localparam logic [VW-1:0] V_LAST = VW'(V_TOT - 1);

   logic          pix_en;
   logic [HW-1:0] h_cnt_q, h_cnt_d;
   logic [VW-1:0] v_cnt_q, v_cnt_d;
   vid_t          vid_q, vid_d;
   logic          line_start_q, line_start_d;
   logic          frame_start_q, frame_start_d;
   logic          h_in_sync, v_in_sync, in_active;

   pix_en_gen #(.CLK_DIV(CLK_DIV)) u_pix_en_gen (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .en_o  (pix_en)
   );

   // Compared at 32 bits: sync end may equal the total and not fit the
   // counter width when the back porch is zero.
   always_comb begin
      h_in_sync = (32'(h_cnt_q) >= HS_BEG) && (32'(h_cnt_q) < HS_END);
      v_in_sync = (32'(v_cnt_q) >= VS_BEG) && (32'(v_cnt_q) < VS_END);
      in_active = (32'(h_cnt_q) < H_ACTIVE) && (32'(v_cnt_q) < V_ACTIVE);
   end

   always_comb begin
      h_cnt_d       = h_cnt_q;
      v_cnt_d       = v_cnt_q;
      vid_d         = vid_q;
      line_start_d  = 1'b0;
      frame_start_d = 1'b0;
      if (pix_en) begin
         vid_d.hsync   = ~h_in_sync;
         vid_d.vsync   = ~v_in_sync;
         vid_d.de      = in_active;
         vid_d.x       = in_active ? COORD_W'(h_cnt_q) : '0;
         vid_d.y       = in_active ? COORD_W'(v_cnt_q) : '0;
         line_start_d  = (h_cnt_q == '0);
         frame_start_d = (h_cnt_q == '0) && (v_cnt_q == '0);
         if (h_cnt_q == H_LAST) begin
            h_cnt_d = '0;
            v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + VW'(1);
         end else begin
            h_cnt_d = h_cnt_q + HW'(1);
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         h_cnt_q       <= '0;
         v_cnt_q       <= '0;
         vid_q         <= VID_IDLE;
         line_start_q  <= 1'b0;
         frame_start_q <= 1'b0;
      end else begin
         h_cnt_q       <= h_cnt_d;
         v_cnt_q       <= v_cnt_d;
         vid_q         <= vid_d;
         line_start_q  <= line_start_d;
         frame_start_q <= frame_start_d;
      end
   end

   assign pix_en_o      = pix_en;
   assign hsync_o       = vid_q.hsync;
   assign vsync_o       = vid_q.vsync;
   assign de_o          = vid_q.de;
   assign x_o           = vid_q.x;
   assign y_o           = vid_q.y;
   assign line_start_o  = line_start_q;
   assign frame_start_o = frame_start_q;

endmodule

// File: tb/tb_vga_timing.sv
// Testbench for vga_timing: three instances (two reduced rasters with
// CLK_DIV=2 and CLK_DIV=1, one default 640x480 raster) share clock and
// reset. Expected pixels come from a raster model indexed by pixel
// number; a producer queues them and a monitor pops and compares them
// on the clock where each pixel's outputs appear.
module tb_vga_timing;

   typedef struct {
      logic        hs;
      logic        vs;
      logic        de;
      logic [9:0]  x;
      logic [9:0]  y;
      logic        ls;
      logic        fs;
      int unsigned e;    // clock edge after reset release where it appears
   } exp_t;

   localparam int unsigned P_CD     [3] = '{2, 1, 2};
   localparam int unsigned P_HA     [3] = '{16, 20, 640};
   localparam int unsigned P_HF     [3] = '{4, 3, 16};
   localparam int unsigned P_HS     [3] = '{6, 5, 96};
   localparam int unsigned P_HB     [3] = '{6, 4, 48};
   localparam int unsigned P_VA     [3] = '{12, 10, 480};
   localparam int unsigned P_VF     [3] = '{2, 1, 10};
   localparam int unsigned P_VS     [3] = '{2, 3, 2};
   localparam int unsigned P_VB     [3] = '{4, 2, 33};
   localparam int unsigned P_MIN_FS [3] = '{3, 3, 2};

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;
   event done;

   always #5 clk = ~clk;

   // Raster model: pixel k of the run after reset, laid out row-major.
   function automatic exp_t model(input int unsigned k, cd, ha, hf, hs, hb,
                                  va, vf, vs, vb);
      exp_t        m;
      int unsigned ht = ha + hf + hs + hb;
      int unsigned vt = va + vf + vs + vb;
      int unsigned p  = k % (ht * vt);
      int unsigned h  = p % ht;
      int unsigned v  = p / ht;
      m.de = (h < ha) && (v < va);
      m.x  = m.de ? 10'(h) : 10'd0;
      m.y  = m.de ? 10'(v) : 10'd0;
      m.hs = !((h >= ha + hf) && (h < ha + hf + hs));
      m.vs = !((v >= va + vf) && (v < va + vf + vs));
      m.ls = (h == 0);
      m.fs = (p == 0);
      m.e  = ((cd < 2) ? 2 : cd) + k * cd;
      return m;
   endfunction

   task automatic check_vec(input string name, input int inst,
                            input logic [25:0] got, input logic [25:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s inst%0d t=%0t got hs/vs/de=%b x=%0d y=%0d ls/fs/pe=%b want hs/vs/de=%b x=%0d y=%0d ls/fs/pe=%b",
                  name, inst, $time, got[25:23], got[22:13], got[12:3], got[2:0],
                  want[25:23], want[22:13], want[12:3], want[2:0]);
      end
   endtask

   task automatic check_int(input string name, input int inst,
                            input int unsigned got, input int unsigned want, input bit at_least);
      checks++;
      if (at_least ? (got < want) : (got != want)) begin
         errors++;
         $display("FAIL %s inst%0d t=%0t got %0d want %s%0d",
                  name, inst, $time, got, at_least ? ">=" : "", want);
      end
   endtask

   for (genvar g = 0; g < 3; g++) begin : g_inst
      localparam int unsigned CD = P_CD[g];
      localparam int unsigned HA = P_HA[g], HF = P_HF[g], HS = P_HS[g], HB = P_HB[g];
      localparam int unsigned VA = P_VA[g], VF = P_VF[g], VS = P_VS[g], VB = P_VB[g];
      localparam int unsigned HT = HA + HF + HS + HB;
      localparam int unsigned VT = VA + VF + VS + VB;
      localparam int unsigned FIRST = (CD < 2) ? 2 : CD;

      vga_timing_if u_if ();

      vga_timing #(
         .CLK_DIV (CD),
         .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
         .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
      ) u_dut (
         .clk_i        (clk),
         .rst_i        (rst),
         .pix_en_o     (u_if.pix_en),
         .hsync_o      (u_if.hsync),
         .vsync_o      (u_if.vsync),
         .de_o         (u_if.de),
         .x_o          (u_if.x),
         .y_o          (u_if.y),
         .line_start_o (u_if.line_start),
         .frame_start_o(u_if.frame_start)
      );

      int unsigned edge_n;
      exp_t        q[$];
      int unsigned nk;
      exp_t        cur;
      bit          have_ls, have_fs;
      int unsigned last_ls, last_fs;
      int unsigned n_ls = 0, n_fs = 0;
      logic [25:0] idle_vec = {3'b110, 10'd0, 10'd0, 3'b000};

      always @(posedge clk or posedge rst) begin
         if (rst) edge_n <= 0;
         else     edge_n <= edge_n + 1;
      end

      // Producer: keeps a few upcoming pixels queued after release.
      always @(posedge clk or posedge rst) begin
         if (rst) begin
            q.delete();
            nk = 0;
         end else begin
            while (q.size() < 4) begin
               q.push_back(model(nk, CD, HA, HF, HS, HB, VA, VF, VS, VB));
               nk++;
            end
         end
      end

      // Reset must take effect without waiting for a clock edge.
      always @(posedge rst) begin
         #1;
         check_vec("async_reset", g,
                   {u_if.hsync, u_if.vsync, u_if.de, u_if.x, u_if.y,
                    u_if.line_start, u_if.frame_start, u_if.pix_en}, idle_vec);
      end

      // Monitor: between pixel updates the outputs must hold and pulses stay low.
      always @(negedge clk) begin
         logic [25:0] got;
         logic        pe;
         exp_t        want;
         got = {u_if.hsync, u_if.vsync, u_if.de, u_if.x, u_if.y,
                u_if.line_start, u_if.frame_start, u_if.pix_en};
         if (rst) begin
            cur = '{hs: 1'b1, vs: 1'b1, de: 1'b0, x: 10'd0, y: 10'd0,
                    ls: 1'b0, fs: 1'b0, e: 0};
            have_ls = 1'b0;
            have_fs = 1'b0;
            check_vec("reset_state", g, got, idle_vec);
         end else begin
            pe = (edge_n + 1 >= FIRST) && (((edge_n + 1 - FIRST) % CD) == 0);
            if (q.size() > 0 && q[0].e == edge_n) begin
               want = q.pop_front();
               check_vec("pixel", g, got,
                         {want.hs, want.vs, want.de, want.x, want.y, want.ls, want.fs, pe});
               cur    = want;
               cur.ls = 1'b0;
               cur.fs = 1'b0;
            end else begin
               check_vec("hold", g, got,
                         {cur.hs, cur.vs, cur.de, cur.x, cur.y, 2'b00, pe});
            end
            if (u_if.line_start) begin
               if (have_ls) check_int("line_period", g, edge_n - last_ls, HT * CD, 1'b0);
               have_ls = 1'b1;
               last_ls = edge_n;
               n_ls++;
            end
            if (u_if.frame_start) begin
               if (have_fs) check_int("frame_period", g, edge_n - last_fs, HT * VT * CD, 1'b0);
               else         check_int("first_frame_edge", g, edge_n, 2, 1'b0);
               have_fs = 1'b1;
               last_fs = edge_n;
               n_fs++;
            end
         end
      end

      always @(done) begin
         check_int("line_starts_seen", g, n_ls, 3, 1'b1);
         check_int("frame_starts_seen", g, n_fs, P_MIN_FS[g], 1'b1);
      end
   end

   initial begin
      repeat (3) @(posedge clk);
      #2 rst = 1'b0;
      repeat ($urandom_range(4400, 3600)) @(posedge clk);
      // Mid-frame reset of random length.
      #2 rst = 1'b1;
      repeat ($urandom_range(4, 1)) @(posedge clk);
      #2 rst = 1'b0;
      repeat ($urandom_range(3700, 3300)) @(posedge clk);
      // Short reset, then a brief random run.
      #2 rst = 1'b1;
      @(posedge clk);
      #2 rst = 1'b0;
      repeat ($urandom_range(400, 50)) @(posedge clk);
      #1 -> done;
      #1;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/vga_timing.md
VGA_TIMING -- requirements
Module: vga_timing

Interface
REQ-001 SHALL have parameter CLK_DIV, default 2, meaning system clocks per pixel; legal range 1..16.
REQ-002 SHALL have parameter H_ACTIVE/H_FP/H_SYNC/H_BP, default 640/16/96/48, meaning horizontal timing in pixels.
REQ-003 SHALL have parameter V_ACTIVE/V_FP/V_SYNC/V_BP, default 480/10/2/33, meaning vertical timing in lines.
REQ-004 SHALL have port clk_i, input, 1, the single system clock (50 MHz nominal).
REQ-005 SHALL have port rst_i, input, 1, reset; asynchronous, active-high.
REQ-006 SHALL have port pix_en_o, output, 1, one-clk pixel strobe.
REQ-007 SHALL have port hsync_o, output, 1, horizontal sync, active-low.
REQ-008 SHALL have port vsync_o, output, 1, vertical sync, active-low.
REQ-009 SHALL have port de_o, output, 1, display enable, high in the active area.
REQ-010 SHALL have port x_o, output, 10, pixel column within the active area, else 0.
REQ-011 SHALL have port y_o, output, 10, pixel row within the active area, else 0.
REQ-012 SHALL have port line_start_o, output, 1, one-clk pulse on the pix_en of h_cnt==0.
REQ-013 SHALL have port frame_start_o, output, 1, one-clk pulse on the pix_en of h_cnt==0 and v_cnt==0; game logic uses it as the update tick.

Function
REQ-014 SHALL assert pix_en_o exactly once every CLK_DIV clocks; with CLK_DIV=1, pix_en_o is held high constantly.
REQ-015 SHALL advance h_cnt by 1 on each pix_en and wrap it from H_TOTAL-1 to 0, where H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP (800 by default).
REQ-016 SHALL advance v_cnt only on the pix_en where h_cnt wraps, and wrap it from V_TOTAL-1 to 0 (V_TOTAL 525 by default).
REQ-017 SHALL drive hsync_o low while H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC (656..751 by default).
REQ-018 SHALL drive vsync_o low while V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC (490..491 by default).
REQ-019 SHALL drive de_o high iff h_cnt<H_ACTIVE and v_cnt<V_ACTIVE.
REQ-020 SHALL drive x_o=h_cnt and y_o=v_cnt while de_o is high, and 0 otherwise.
REQ-021 SHALL register hsync_o, vsync_o, de_o, x_o and y_o, so they reflect the counter state with exactly 1 clk latency, all aligned together.
REQ-022 SHALL change hsync_o, vsync_o, de_o, x_o and y_o only on the clock following a pix_en, holding them stable for CLK_DIV clocks.
REQ-023 SHALL align line_start_o and frame_start_o to the same clock as the de_o/x_o/y_o update of that pixel.
REQ-024 SHALL size the counters to hold H_TOTAL-1 and V_TOTAL-1, with no overflow at wrap.
REQ-025 SHALL, on the pix_en of the last pixel of the frame (h_cnt=799, v_cnt=524), wrap both counters to 0 on that same pix_en.

Reset
REQ-026 SHALL, while rst_i=1, immediately force h_cnt=0, v_cnt=0, divider=0, pix_en_o=0, hsync_o=1, vsync_o=1, de_o=0, x_o=0, y_o=0, line_start_o=0 and frame_start_o=0.
REQ-027 SHALL deliver the first pix_en after rst_i deasserts CLK_DIV clocks later, with frame_start_o on that pix_en (h_cnt=0, v_cnt=0).
REQ-028 SHALL abandon a frame on reset asserted mid-frame, with no partial sync pulse after release.

Structure
REQ-029 SHALL place the default timing constants, H_TOTAL/V_TOTAL, and the coordinate width localparam (10) in shared package vga_pkg.
REQ-030 SHALL implement the pixel strobe divider as sub-module pix_en_gen (parameter CLK_DIV, ports clk_i, rst_i, en_o).

Verification
REQ-031 SHALL cover default parameters, CLK_DIV=2: consecutive line_start_o pulses are 1600 clks apart, and consecutive frame_start_o pulses are 840000 clks apart.
REQ-032 SHALL cover hsync_o: low for exactly 96 pix_en (192 clks) per line, first falling 1 clk after the pix_en of h_cnt=656.
REQ-033 SHALL cover vsync_o: low for exactly 2 lines (1600 pix_en), starting at v_cnt=490; over one frame de_o is high for 307200 pix_en.
REQ-034 SHALL cover coordinates: de_o rises with x_o=0, y_o=0; the last active pixel shows x_o=639, y_o=479; then de_o drops and x_o=y_o=0.
REQ-035 SHALL cover rst_i pulsed at v_cnt=300, h_cnt=700: outputs reach reset values asynchronously, and frame_start_o is seen 2 clks after release.
REQ-036 SHALL cover CLK_DIV=1: pix_en_o is constant high and the frame period is 420000 clks.
